uart_tx_arbiter: RTL and testbench

//  Shares the single uart_tx transmitter between two requesters:
//  - Control path: single bytes, e.g. the 0xAA loader handshake.
//  - Program output path: OP_OUT bytes, buffered in an internal ring FIFO.

---
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx transmitter between a control requester (single bytes,
//   e.g. the 0xAA loader handshake) and a program-output path buffered in an
//   internal ring FIFO. Each launch is a one-cycle tx_start pulse followed by a
//   wait for the transmitter's busy window to close. The control path has
//   fixed priority over the FIFO.
//
//   Ports
//     clk, rstn              clock (rising edge), async active-low reset
//     push_valid/data/ready  program byte into the FIFO (ready = not full)
//     tx_en                  1: FIFO may drain, 0: FIFO held
//     ctl_req/data/ack       control byte request, held until the ack pulse
//     tx_data/tx_start       byte and launch pulse towards uart_tx
//     tx_busy                uart_tx busy, ignored for START_LAT cycles after launch
//     fifo_count             bytes currently buffered (0..DEPTH)
//     idle                   FSM idle and FIFO empty
module uart_tx_arbiter #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned START_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push_valid,
  input  logic [7:0]        push_data,
  output logic              push_ready,
  input  logic              tx_en,
  input  logic              ctl_req,
  input  logic [7:0]        ctl_data,
  output logic              ctl_ack,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              idle
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_FW  = ADDR_W + 1;
  // Launch-latency counter only has to reach START_LAT-1.
  localparam int unsigned LAT_W   = (START_LAT > 1) ? $clog2(START_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(START_LAT - 1);
  localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_FW-1:0]   count_q, count_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                ctl_ack_q, ctl_ack_d;
  logic                push_ready_q, push_ready_d;
  logic                idle_q, idle_d;
  logic [7:0]          mem_q [DEPTH];

  logic                push_fire_c;
  logic                pop_c;

  // Acceptance uses the registered ready, so a full FIFO refuses even when popping.
  assign push_fire_c = push_valid && push_ready_q;

  // FIFO storage; no reset, entries are only read when counted as valid.
  always_ff @(posedge clk) begin
    if (push_fire_c) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Write pointer and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_fire_c) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    case ({push_fire_c, pop_c})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
  end

  // Launch sequencer: pick a source in IDLE, blind ARM window, then wait for !tx_busy.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    rd_ptr_d   = rd_ptr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ctl_ack_d  = 1'b0;
    pop_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctl_req) begin
          tx_data_d  = ctl_data;
          tx_start_d = 1'b1;
          ctl_ack_d  = 1'b1;
          lat_d      = '0;
          state_d    = ST_ARM;
        end else if (tx_en && (count_q != '0)) begin
          tx_data_d  = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
          pop_c      = 1'b1;
          tx_start_d = 1'b1;
          lat_d      = '0;
          state_d    = ST_ARM;
        end
      end

      // tx_busy may not have risen yet, so it is not looked at here.
      ST_ARM: begin
        if (lat_q == LAT_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      ST_DRAIN: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    push_ready_d = (count_d != FULL_CNT);
    idle_d       = (state_d == ST_IDLE) && (count_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      lat_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      ctl_ack_q    <= 1'b0;
      push_ready_q <= 1'b1;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      ctl_ack_q    <= ctl_ack_d;
      push_ready_q <= push_ready_d;
      idle_q       <= idle_d;
    end
  end

  assign push_ready = push_ready_q;
  assign ctl_ack    = ctl_ack_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign fifo_count = count_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Models uart_tx (busy rises one cycle after
// tx_start, stays high 10 cycles) and scores every launch against a queue of
// accepted program bytes plus the pending control byte.
module tb_uart_tx_arbiter;

  localparam int DEPTH     = 16;
  localparam int START_LAT = 2;

  logic       clk;
  logic       rstn;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_ready;
  logic       tx_en;
  logic       ctl_req;
  logic [7:0] ctl_data;
  logic       ctl_ack;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [4:0] fifo_count;
  logic       idle;

  uart_tx_arbiter #(.ADDR_W(4), .START_LAT(START_LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .tx_en      (tx_en),
    .ctl_req    (ctl_req),
    .ctl_data   (ctl_data),
    .ctl_ack    (ctl_ack),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and uart_tx busy model.
  int         cyc = 0;
  logic [3:0] busy_cnt = 4'd0;
  bit         busy_tie0 = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy_tie0)             busy_cnt <= 4'd0;
    else if (tx_start === 1'b1) busy_cnt <= 4'd10;
    else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
  end
  assign tx_busy = (busy_cnt != 4'd0);

  // Scoreboard state.
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         m_count = 0;
  int         last_start = -1;
  int         ev_cyc[$];
  logic [7:0] ev_dat[$];
  logic       ev_ack[$];

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were set at the current negedge; observe at the next one.
  task automatic tick();
    logic       acc, req_e, en_e, busy_e;
    logic [7:0] pd, ctl_e, exp_b;
    int         sp;
    acc    = push_valid && (m_count != DEPTH);
    req_e  = ctl_req;
    en_e   = tx_en;
    busy_e = tx_busy;
    pd     = push_data;
    ctl_e  = ctl_data;
    @(posedge clk);
    @(negedge clk);
    if (tx_start === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_dat.push_back(tx_data);
      ev_ack.push_back(ctl_ack);
      chk(32'(busy_e), 32'd0, "launch_while_busy");
      if (last_start >= 0) begin
        sp = cyc - last_start;
        chk(32'(sp >= START_LAT + 2), 32'd1, "start_spacing_min");
      end
      last_start = cyc;
      chk(32'(ctl_ack), 32'(req_e), "ack_matches_ctl_req");
      if (req_e) begin
        chk(32'(tx_data), 32'(ctl_e), "ctl_byte");
        ctl_req = 1'b0;
      end else begin
        chk(32'(en_e), 32'd1, "pop_needs_tx_en");
        if (exp_q.size() == 0) begin
          chk(32'(tx_data), 32'h100, "pop_from_empty");
        end else begin
          exp_b = exp_q.pop_front();
          m_count--;
          chk(32'(tx_data), 32'(exp_b), "fifo_byte");
        end
      end
    end else begin
      chk(32'(ctl_ack), 32'd0, "ack_without_start");
    end
    if (acc) begin
      exp_q.push_back(pd);
      m_count++;
    end
    chk(32'(fifo_count), 32'(m_count), "fifo_count");
    chk(32'(push_ready), 32'(m_count != DEPTH), "push_ready");
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ctl_req) && n < limit) begin
      tick();
      n++;
    end
    chk(32'(exp_q.size()), 32'd0, "drain_timeout");
    repeat (15) tick();
    chk(32'(idle), 32'd1, "idle_after_drain");
  endtask

  task automatic push_one(input logic [7:0] d);
    push_valid = 1'b1;
    push_data  = d;
    tick();
    push_valid = 1'b0;
  endtask

  initial begin
    int n0, c0, n_before;
    rstn = 1'b1; push_valid = 1'b0; push_data = 8'h00;
    tx_en = 1'b0; ctl_req = 1'b0; ctl_data = 8'h00;

    // Power-on reset values.
    #3 rstn = 1'b0;
    #1;
    chk(32'(tx_start), 32'd0, "rst_tx_start");
    chk(32'(ctl_ack), 32'd0, "rst_ctl_ack");
    chk(32'(tx_data), 32'd0, "rst_tx_data");
    chk(32'(fifo_count), 32'd0, "rst_fifo_count");
    chk(32'(push_ready), 32'd1, "rst_push_ready");
    chk(32'(idle), 32'd1, "rst_idle");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // 1: reset while draining a control byte with five bytes buffered.
    for (int i = 0; i < 5; i++) push_one(8'(8'h10 + i));
    ctl_data = 8'hAA; ctl_req = 1'b1;
    for (int i = 0; i < 5 && ctl_req; i++) tick();
    chk(32'(ctl_req), 32'd0, "t1_ctl_launched");
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    chk(32'(tx_start), 32'd0, "t1_rst_tx_start");
    chk(32'(ctl_ack), 32'd0, "t1_rst_ctl_ack");
    chk(32'(fifo_count), 32'd0, "t1_rst_fifo_count");
    chk(32'(push_ready), 32'd1, "t1_rst_push_ready");
    chk(32'(idle), 32'd1, "t1_rst_idle");
    exp_q.delete(); m_count = 0; last_start = -1;
    @(negedge clk);
    rstn = 1'b1;
    tx_en = 1'b1;
    n_before = ev_cyc.size();
    repeat (30) tick();
    chk(32'(ev_cyc.size()), 32'(n_before), "t1_no_start_after_reset");

    // 2: three back-to-back bytes, first launch one cycle after acceptance.
    n0 = ev_cyc.size(); c0 = cyc;
    push_valid = 1'b1;
    push_data = 8'h41; tick();
    push_data = 8'h42; tick();
    push_data = 8'h43; tick();
    push_valid = 1'b0;
    drain(100);
    chk(32'(ev_cyc.size()), 32'(n0 + 3), "t2_three_starts");
    if (ev_cyc.size() >= n0 + 1) chk(32'(ev_cyc[n0]), 32'(c0 + 2), "t2_first_latency");

    // 3: control byte beats a held FIFO byte when tx_en rises with ctl_req.
    tx_en = 1'b0;
    push_one(8'h55);
    repeat (2) tick();
    n0 = ev_cyc.size(); c0 = cyc;
    ctl_data = 8'hAA; ctl_req = 1'b1; tx_en = 1'b1;
    drain(100);
    chk(32'(ev_cyc.size()), 32'(n0 + 2), "t3_two_starts");
    if (ev_cyc.size() >= n0 + 2) begin
      chk(32'(ev_dat[n0]), 32'hAA, "t3_first_ctl");
      chk(32'(ev_ack[n0]), 32'd1, "t3_first_ack");
      chk(32'(ev_cyc[n0]), 32'(c0 + 1), "t3_ctl_latency");
      chk(32'(ev_dat[n0 + 1]), 32'h55, "t3_second_fifo");
      chk(32'(ev_ack[n0 + 1]), 32'd0, "t3_second_no_ack");
    end

    // 4: overfill with 17 bytes, then drain through the pointer wrap.
    tx_en = 1'b0;
    push_valid = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      push_data = 8'(i);
      tick();
    end
    push_valid = 1'b0;
    chk(32'(fifo_count), 32'd16, "t4_full_count");
    chk(32'(push_ready), 32'd0, "t4_full_not_ready");
    n0 = ev_cyc.size();
    tx_en = 1'b1;
    drain(400);
    chk(32'(ev_cyc.size()), 32'(n0 + 16), "t4_sixteen_starts");
    if (ev_dat.size() >= n0 + 16) chk(32'(ev_dat[n0 + 15]), 32'h0F, "t4_last_byte");

    // 5: full FIFO with pop and push in the same cycle refuses the push.
    tx_en = 1'b0;
    push_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_data = 8'(8'h20 + i);
      tick();
    end
    push_data = 8'h99; tx_en = 1'b1;
    tick();
    push_valid = 1'b0;
    chk(32'(fifo_count), 32'd15, "t5_pop_refuses_push");
    drain(400);

    // 6: tx_busy stuck low gives minimum launch spacing.
    busy_tie0 = 1'b1;
    @(negedge clk);
    n0 = ev_cyc.size();
    push_valid = 1'b1;
    push_data = 8'h7E; tick();
    push_data = 8'h7F; tick();
    push_valid = 1'b0;
    drain(50);
    chk(32'(ev_cyc.size()), 32'(n0 + 2), "t6_two_starts");
    if (ev_cyc.size() >= n0 + 2)
      chk(32'(ev_cyc[n0 + 1] - ev_cyc[n0]), 32'(START_LAT + 2), "t6_exact_spacing");
    busy_tie0 = 1'b0;
    repeat (2) tick();

    // Random mix of pushes, tx_en toggles and control requests.
    for (int i = 0; i < 400; i++) begin
      push_valid = ($urandom_range(2) == 0);
      push_data  = 8'($urandom);
      if ($urandom_range(19) == 0) tx_en = !tx_en;
      if (!ctl_req && tx_start !== 1'b1 && $urandom_range(39) == 0) begin
        ctl_data = 8'($urandom);
        ctl_req  = 1'b1;
      end
      tick();
    end
    push_valid = 1'b0;
    tx_en = 1'b1;
    drain(800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
